// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide unit: 32-cycle shift-add multiply and
// 32-cycle restoring divide on operand magnitudes, with single-cycle divide corner cases.
`timescale 1ns/1ps
module muldiv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        md_start_e,
  input  logic [2:0]  md_op_e,
  input  logic [31:0] md_opa_e,
  input  logic [31:0] md_opb_e,
  input  logic        flush_e,
  output logic        md_busy_e,
  output logic        md_stall_e,
  output logic        md_done_e,
  output logic [31:0] md_result_e
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [5:0] LAST_ITER = 6'd31;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic        flip_q, flip_d;
  logic        flip_rem_q, flip_rem_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] result_q, result_d;

  logic        accept;
  logic        signed_a, signed_b, neg_a, neg_b;
  logic [31:0] abs_a, abs_b;
  logic        div_by_zero, div_ovf;
  logic [32:0] mul_sum;
  logic [63:0] mul_next, mul_fix;
  logic [32:0] rem_sh, rem_diff;
  logic [63:0] div_next;
  logic [31:0] quo_fix, rem_fix, final_res;

  assign accept = rst_n & md_start_e & ~flush_e &
                  ((state_q == S_IDLE) | (state_q == S_DONE));

  // Operand signedness decoded from the incoming op, so magnitudes are latched at start.
  assign signed_a = (md_op_e == OP_MULH) | (md_op_e == OP_MULHSU) |
                    (md_op_e == OP_DIV)  | (md_op_e == OP_REM);
  assign signed_b = (md_op_e == OP_MULH) | (md_op_e == OP_DIV) | (md_op_e == OP_REM);
  assign neg_a    = signed_a & md_opa_e[31];
  assign neg_b    = signed_b & md_opb_e[31];
  assign abs_a    = neg_a ? -md_opa_e : md_opa_e;
  assign abs_b    = neg_b ? -md_opb_e : md_opb_e;

  assign div_by_zero = md_op_e[2] & (md_opb_e == 32'd0);
  assign div_ovf     = md_op_e[2] & ~md_op_e[0] &
                       (md_opa_e == 32'h8000_0000) & (md_opb_e == 32'hFFFF_FFFF);

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opa_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};
  assign mul_fix  = flip_q ? -mul_next : mul_next;

  // Divide: acc = {partial remainder, dividend/quotient}, shifted left each step.
  assign rem_sh   = {acc_q[63:32], acc_q[31]};
  assign rem_diff = rem_sh - {1'b0, opb_q};
  assign div_next = rem_diff[32] ? {rem_sh[31:0], acc_q[30:0], 1'b0}
                                 : {rem_diff[31:0], acc_q[30:0], 1'b1};
  assign quo_fix  = flip_q     ? -div_next[31:0]  : div_next[31:0];
  assign rem_fix  = flip_rem_q ? -div_next[63:32] : div_next[63:32];

  always_comb begin
    final_res = 32'd0;
    if (op_q[2])                final_res = op_q[1] ? rem_fix : quo_fix;
    else if (op_q[1:0] == 2'b00) final_res = mul_fix[31:0];
    else                         final_res = mul_fix[63:32];
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    flip_d     = flip_q;
    flip_rem_d = flip_rem_q;
    acc_d      = acc_q;
    result_d   = result_q;

    case (state_q)
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) begin
          acc_d    = mul_fix;
          result_d = final_res;
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) begin
          acc_d    = {rem_fix, quo_fix};
          result_d = final_res;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      op_d       = md_op_e;
      opa_d      = abs_a;
      opb_d      = abs_b;
      flip_d     = neg_a ^ neg_b;
      flip_rem_d = md_op_e[2] & neg_a;
      cnt_d      = 6'd0;
      if (div_by_zero) begin
        acc_d    = 64'd0;
        result_d = md_op_e[1] ? md_opa_e : 32'hFFFF_FFFF;
        state_d  = S_DONE;
      end else if (div_ovf) begin
        acc_d    = 64'd0;
        result_d = md_op_e[1] ? 32'd0 : 32'h8000_0000;
        state_d  = S_DONE;
      end else if (md_op_e[2]) begin
        acc_d   = {32'd0, abs_a};
        state_d = S_DIV;
      end else begin
        acc_d   = {32'd0, abs_b};
        state_d = S_MUL;
      end
    end

    // A flush on the final iteration must not publish that result either.
    if (flush_e) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 6'd0;
      op_q       <= 3'd0;
      opa_q      <= 32'd0;
      opb_q      <= 32'd0;
      flip_q     <= 1'b0;
      flip_rem_q <= 1'b0;
      acc_q      <= 64'd0;
      result_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      opa_q      <= opa_d;
      opb_q      <= opb_d;
      flip_q     <= flip_d;
      flip_rem_q <= flip_rem_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
    end
  end

  assign md_busy_e   = (state_q == S_MUL) | (state_q == S_DIV);
  assign md_stall_e  = md_busy_e | accept;
  assign md_done_e   = (state_q == S_DONE);
  assign md_result_e = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        md_start_e;
  logic [2:0]  md_op_e;
  logic [31:0] md_opa_e;
  logic [31:0] md_opb_e;
  logic        flush_e;
  logic        md_busy_e;
  logic        md_stall_e;
  logic        md_done_e;
  logic [31:0] md_result_e;

  int n_checks = 0;
  int n_pass   = 0;

  muldiv_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .md_start_e  (md_start_e),
    .md_op_e     (md_op_e),
    .md_opa_e    (md_opa_e),
    .md_opb_e    (md_opb_e),
    .flush_e     (flush_e),
    .md_busy_e   (md_busy_e),
    .md_stall_e  (md_stall_e),
    .md_done_e   (md_done_e),
    .md_result_e (md_result_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model: plain 64-bit / integer arithmetic from the RV32M rules.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Present a start in the current cycle; it must be accepted at the coming edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    md_start_e = 1'b1;
    flush_e    = 1'b0;
    md_op_e    = op;
    md_opa_e   = a;
    md_opb_e   = b;
    #1;
    check("stall_on_accept", md_stall_e, 1'b1);
  endtask

  // Scramble inputs after acceptance and wait for md_done_e; optionally re-assert
  // md_start_e in cycle inj_k to confirm it is ignored while busy.
  task automatic finish_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int inj_k);
    int lat, k;
    bit busy_ok;
    lat     = ref_latency(op, a, b);
    busy_ok = 1'b1;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      md_start_e = (k == inj_k);
      md_op_e    = 3'($urandom_range(0, 7));
      md_opa_e   = $urandom;
      md_opb_e   = $urandom;
      #1;
      if (md_done_e === 1'b1) break;
      if (!(md_busy_e === 1'b1 && md_stall_e === 1'b1)) busy_ok = 1'b0;
    end
    check({tag, "_latency"}, 64'(k), 64'(lat));
    check({tag, "_result"}, md_result_e, ref_result(op, a, b));
    check({tag, "_done_not_busy"}, {md_busy_e, md_stall_e}, 2'b00);
    if (lat > 1) check({tag, "_busy_stall_while_running"}, busy_ok, 1'b1);
  endtask

  // One cycle after DONE with no new start: back to idle, result held.
  task automatic idle_check(input string tag, input logic [31:0] res);
    @(negedge clk);
    md_start_e = 1'b0;
    #1;
    check({tag, "_idle_flags"}, {md_done_e, md_busy_e, md_stall_e}, 3'b000);
    check({tag, "_held"}, md_result_e, res);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b, last_res;
    bit          b2b;
    bit          done_seen;

    rst_n = 1'b0; md_start_e = 1'b1; flush_e = 1'b0;
    md_op_e = 3'd0; md_opa_e = 32'd0; md_opb_e = 32'd0;
    #3;
    check("reset_outputs", {md_busy_e, md_stall_e, md_done_e, md_result_e}, 35'd0);

    // First start accepted on the first edge after reset release.
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
    finish_op("mulh_neg2x3", 3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 0);
    idle_check("mulh_neg2x3", 32'hFFFF_FFFF);

    @(negedge clk); issue(3'd0, 32'hFFFF_FFFE, 32'h0000_0003);
    finish_op("mul_neg2x3", 3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 0);
    idle_check("mul_neg2x3", 32'hFFFF_FFFA);

    @(negedge clk); issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    finish_op("div_neg7by2", 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    idle_check("div_neg7by2", 32'hFFFF_FFFD);

    @(negedge clk); issue(3'd6, 32'hFFFF_FFF9, 32'd2);
    finish_op("rem_neg7by2", 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    idle_check("rem_neg7by2", 32'hFFFF_FFFF);

    // Fast paths, the last two back-to-back so done is high in consecutive cycles.
    @(negedge clk); issue(3'd5, 32'd5, 32'd0);
    finish_op("divu_by0", 3'd5, 32'd5, 32'd0, 0);
    idle_check("divu_by0", 32'hFFFF_FFFF);
    @(negedge clk); issue(3'd7, 32'd5, 32'd0);
    finish_op("remu_by0", 3'd7, 32'd5, 32'd0, 0);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    idle_check("rem_ovf", 32'd0);

    // A start asserted mid-operation is ignored; the original op completes on time.
    @(negedge clk); issue(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
    finish_op("mulhu_inj", 3'd3, 32'hDEAD_BEEF, 32'h1234_5678, 5);
    last_res = ref_result(3'd3, 32'hDEAD_BEEF, 32'h1234_5678);
    idle_check("mulhu_inj", last_res);

    // Flush at cycle 10 of a MULHU, with an ignored start at cycle 5.
    @(negedge clk); issue(3'd3, 32'hCAFE_F00D, 32'h0BAD_0BAD);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      md_start_e = (c == 5);
      flush_e    = (c == 10);
    end
    @(negedge clk);
    md_start_e = 1'b0; flush_e = 1'b0;
    #1;
    check("flush_idle", {md_busy_e, md_done_e}, 2'b00);
    check("flush_result_held", md_result_e, last_res);
    done_seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (md_done_e !== 1'b0) done_seen = 1'b1;
    end
    check("flush_no_done", done_seen, 1'b0);

    // Flush wins over a simultaneous start.
    @(negedge clk);
    md_start_e = 1'b1; flush_e = 1'b1;
    #1;
    check("flush_prio_stall", md_stall_e, 1'b0);
    @(negedge clk);
    md_start_e = 1'b0; flush_e = 1'b0;
    #1;
    check("flush_prio_idle", {md_busy_e, md_done_e}, 2'b00);

    // Back-to-back: second start presented in the DONE cycle of the first.
    @(negedge clk); issue(3'd5, 32'd100, 32'd7);
    finish_op("b2b_divu", 3'd5, 32'd100, 32'd7, 0);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("b2b_mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    idle_check("b2b_mulhu", 32'hFFFF_FFFE);

    // Reset asserted at cycle 20 of a DIV.
    @(negedge clk); issue(3'd4, 32'h7654_3210, 32'd3);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      md_start_e = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    check("midop_reset_outputs", {md_busy_e, md_stall_e, md_done_e, md_result_e}, 35'd0);
    @(negedge clk); #1;
    check("midop_reset_no_done", md_done_e, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'd6, 32'hFFFF_FF9C, 32'd7);
    finish_op("after_reset_rem", 3'd6, 32'hFFFF_FF9C, 32'd7, 0);
    last_res = ref_result(3'd6, 32'hFFFF_FF9C, 32'd7);
    idle_check("after_reset_rem", last_res);

    // Randomized operations, sometimes chained back-to-back from DONE.
    b2b = 1'b0;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      if (!b2b) @(negedge clk);
      issue(op, a, b);
      finish_op("rand", op, a, b, (i % 4 == 0) ? 7 : 0);
      last_res = ref_result(op, a, b);
      b2b = ($urandom_range(0, 2) == 0);
      if (!b2b) idle_check("rand", last_res);
    end
    if (b2b) idle_check("rand_tail", last_res);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and rst_n.
REQ-002 The block SHALL expose the following ports, one per line:
- clk  in  1  execute-stage clock.
- rst_n  in  1  asynchronous active-low reset.
- md_start_e  in  1  request to start an M-extension operation this cycle.
- md_op_e  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- md_opa_e  in  32  operand A (rs1 / dividend).
- md_opb_e  in  32  operand B (rs2 / divisor).
- flush_e  in  1  pipeline flush; aborts any in-flight operation.
- md_busy_e  out  1  operation in progress.
- md_stall_e  out  1  hold the upstream pipeline stages.
- md_done_e  out  1  one-cycle pulse: md_result_e is valid.
- md_result_e  out  32  result, held until the next accepted start or reset.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, MUL, DIV and DONE.
REQ-004 A start SHALL be accepted only when md_start_e=1, flush_e=0, and the state is IDLE or DONE; a start in MUL or DIV SHALL be ignored.
REQ-005 On acceptance, the block SHALL latch md_op_e, md_opa_e and md_opb_e; later changes on those inputs SHALL have no effect.
REQ-006 Accepted op[2]=0 SHALL go to MUL; op[2]=1 SHALL go to DIV, except for the fast-path cases in REQ-011 and REQ-012.
REQ-007 MUL SHALL run 32 iterations of 1 bit/cycle shift-add on operand magnitudes into a 64-bit accumulator, with a 6-bit iteration counter.
- MULH treats both operands as signed; MULHSU treats A as signed and B as unsigned; MUL and MULHU treat both as unsigned.
- The sign correction (two's complement of the 64-bit product) SHALL be applied at the end of the last iteration.
REQ-008 DIV SHALL run 32 iterations of 1 bit/cycle restoring division on operand magnitudes.
- Signed quotient rounds toward zero.
- Signed remainder takes the sign of the dividend.
REQ-009 Latency for a start accepted at edge T:
- iterations occupy cycles T+1..T+32;
- DONE is entered at T+33 with md_done_e=1 for exactly that cycle;
- the state returns to IDLE at T+34 unless a new start is accepted in DONE.
REQ-010 Result selection:
- MUL returns product[31:0].
- MULH, MULHSU and MULHU return product[63:32].
- DIV and DIVU return the quotient.
- REM and REMU return the remainder.
REQ-011 Divide-by-zero (opb=0) SHALL skip DIV and enter DONE at T+1.
- DIV/DIVU quotient = 32'hFFFF_FFFF.
- REM/REMU remainder = opa.
REQ-012 Signed overflow (DIV/REM with opa=32'h8000_0000 and opb=32'hFFFF_FFFF) SHALL enter DONE at T+1 with quotient 32'h8000_0000 and remainder 0.
REQ-013 md_busy_e SHALL be 1 exactly in MUL and DIV.
REQ-014 md_stall_e SHALL equal md_busy_e OR (start accepted this cycle), combinationally; it SHALL be 0 in DONE unless a new start is accepted there.
REQ-015 flush_e=1 SHALL force IDLE at the next edge from any state, with no md_done_e pulse.
- md_result_e SHALL keep its previous value.
- flush_e SHALL take priority over a simultaneous md_start_e.
REQ-016 A start accepted in DONE SHALL be processed exactly as one accepted in IDLE, giving back-to-back operations with no idle cycle.
REQ-017 md_done_e SHALL never be 1 in two consecutive cycles except for back-to-back fast-path operations.

Reset
REQ-018 While rst_n=0, the block SHALL asynchronously force:
- state to IDLE;
- counter, accumulators and latched operands to 0;
- md_busy_e, md_stall_e and md_done_e to 0;
- md_result_e to 32'h0000_0000.
REQ-019 Assertion of rst_n mid-operation SHALL abort the operation with no md_done_e pulse.
REQ-020 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-021 MULH with opa=32'hFFFF_FFFE (-2) and opb=32'h0000_0003 -> md_done_e at T+33, md_result_e=32'hFFFF_FFFF; with op=MUL -> 32'hFFFF_FFFA.
REQ-022 DIV with opa=32'hFFFF_FFF9 (-7) and opb=2 -> quotient 32'hFFFF_FFFD at T+33; REM with the same operands -> 32'hFFFF_FFFF; md_stall_e=1 from T through T+32.
REQ-023 Fast paths:
- DIVU 5/0 -> 32'hFFFF_FFFF at T+1.
- REMU 5/0 -> 5 at T+1.
- DIV 32'h8000_0000/-1 -> 32'h8000_0000 at T+1.
REQ-024 flush_e at T+10 of a MULHU -> IDLE at T+11, no md_done_e, md_result_e unchanged; a md_start_e at T+5 during the MULHU is ignored.
REQ-025 Back-to-back: DIVU 100/7 then, in DONE, MULHU 32'hFFFF_FFFF*32'hFFFF_FFFF -> results 14 at T+33 and 32'hFFFF_FFFE at T+67.
REQ-026 rst_n pulled low at T+20 of a DIV -> all outputs 0 immediately; a new start after release completes normally.
